xbar_feeder: RTL and testbench

- Upstream stage of the crossbar model: packs a serial stream of `QW`-bit elements (shortreal bit patterns) into `XH`-lane input vectors and issues them over the crossbar's toggle handshake.
- Supports non-aligned rows: a vector may be closed early by last_i, and its unused lanes are zero-padded.
- Uses ping-pong buffering, so one vector can be packed while the crossbar processes the previous one.

---
 rtl/xbar_feeder_if.sv | 57 +++++
 rtl/xbar_feeder.sv | 194 +++++++++++++++++++
 tb/tb_xbar_feeder.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xbar_feeder_if.sv
// -----------------------------------------------------------------------------
// xbar_feeder_if
//   Bundles the element stream (upstream side) and the toggle-handshake vector
//   link (crossbar side) of the crossbar feeder.
//
//   Signals
//     data_i      [`QW]       stream element (shortreal bit pattern)
//     valid_i                 element valid
//     ready_o                 element accepted when valid_i && ready_o
//     last_i                  close current vector after this element
//     vector_o    [`QW]x`XH   vector presented to the crossbar
//     valid_o_tg              toggles once per issued vector
//     ready_i_tg              crossbar toggles once per consumed vector
//
//   Modports
//     master : the feeder itself
//     slave  : the environment (stream producer + crossbar)
//
//   `XH / `QW normally come from params.svh; the guarded defaults below keep
//   this file self-contained when that header is not on the include path.
// -----------------------------------------------------------------------------
`ifndef XH
`define XH 4
`endif
`ifndef QW
`define QW 32
`endif

interface xbar_feeder_if;
    logic [`QW-1:0] data_i;
    logic           valid_i;
    logic           ready_o;
    logic           last_i;
    logic [`QW-1:0] vector_o [`XH];
    logic           valid_o_tg;
    logic           ready_i_tg;

    modport master (
        input  data_i,
        input  valid_i,
        input  last_i,
        input  ready_i_tg,
        output ready_o,
        output vector_o,
        output valid_o_tg
    );

    modport slave (
        output data_i,
        output valid_i,
        output last_i,
        output ready_i_tg,
        input  ready_o,
        input  vector_o,
        input  valid_o_tg
    );
endinterface

// File: rtl/xbar_feeder.sv
// -----------------------------------------------------------------------------
// xbar_feeder
//   Packs a serial stream of `QW-bit elements into `XH-lane vectors and issues
//   them to the crossbar over a toggle handshake. Two ping-pong buffers let one
//   vector be packed while the crossbar works on the previous one. A vector may
//   be closed early with last_i; its unused upper lanes are zero-padded.
//
//   Ports
//     clk        clock
//     rstn       asynchronous active-low reset
//     bus        xbar_feeder_if.master (stream in, vector/toggle handshake out)
//     busy_o     any buffer pending or an issue in flight
//   Optional (macro XBAR_FEEDER_STATS_EN)
//     vec_cnt_o  [32]  vectors released by the crossbar (wraps)
//     pad_cnt_o  [32]  vectors closed early by last_i with fewer than `XH lanes
//     spurious_o       sticky: ready toggle seen outside WAIT
//
//   Parameters
//     SYNC_STAGES  flops in the ready_i_tg synchroniser (2..3)
//     ISSUE_GAP    idle cycles between a release and the next issue (0..7)
// -----------------------------------------------------------------------------
`ifndef XH
`define XH 4
`endif
`ifndef QW
`define QW 32
`endif

module xbar_feeder #(
    parameter int SYNC_STAGES = 2,
    parameter int ISSUE_GAP   = 1
) (
    input  logic                clk,
    input  logic                rstn,
    xbar_feeder_if.master       bus,
    output logic                busy_o
`ifdef XBAR_FEEDER_STATS_EN
    ,
    output logic [31:0]         vec_cnt_o,
    output logic [31:0]         pad_cnt_o,
    output logic                spurious_o
`endif
);

    localparam int LW = (`XH > 1) ? $clog2(`XH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT
    } state_t;

    // Ping-pong storage; data only, never reset (lanes are always written or
    // zero-padded before a buffer is marked pending).
    logic [`QW-1:0]         buf_mem [2][`XH];

    logic [1:0]             pending;
    logic                   fill_ptr;
    logic                   issue_ptr;
    logic [LW-1:0]          lane_cnt;
    state_t                 state;
    logic [2:0]             gap_cnt;
    logic [SYNC_STAGES-1:0] sync_q;

    logic                   ready_pulse;
    logic                   accept;
    logic                   close_buf;
    logic                   release_buf;
    logic                   load_vec;
    logic [1:0]             pending_nxt;
    logic                   fill_ptr_nxt;

    // Edge detect on the two oldest synchroniser stages: one cycle per toggle.
    assign ready_pulse = sync_q[SYNC_STAGES-1] ^ sync_q[SYNC_STAGES-2];

    assign accept      = bus.valid_i && bus.ready_o;
    assign close_buf   = accept && ((lane_cnt == LW'(`XH - 1)) || bus.last_i);
    assign release_buf = (state == ST_WAIT) && ready_pulse;
    assign load_vec    = (state == ST_IDLE) && pending[issue_ptr] && (gap_cnt == 3'd0);

    // Close and release never hit the same buffer: the buffer in WAIT is
    // pending, so the fill side cannot be writing it.
    always_comb begin
        pending_nxt = pending;
        if (release_buf) begin
            pending_nxt[issue_ptr] = 1'b0;
        end
        if (close_buf) begin
            pending_nxt[fill_ptr] = 1'b1;
        end
    end

    assign fill_ptr_nxt = close_buf ? ~fill_ptr : fill_ptr;

    assign busy_o = pending[0] | pending[1] | (state != ST_IDLE);

    // ---- fill datapath: lane write, zero-pad of upper lanes on close ----
    always_ff @(posedge clk) begin
        for (int i = 0; i < `XH; i++) begin
            if (accept) begin
                if (i == int'(lane_cnt)) begin
                    buf_mem[fill_ptr][i] <= bus.data_i;
                end else if (close_buf && (i > int'(lane_cnt))) begin
                    buf_mem[fill_ptr][i] <= '0;
                end
            end
        end
    end

    // ---- synchroniser, fill control, issue FSM ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q         <= '0;
            pending        <= 2'b00;
            fill_ptr       <= 1'b0;
            issue_ptr      <= 1'b0;
            lane_cnt       <= '0;
            state          <= ST_IDLE;
            gap_cnt        <= 3'd0;
            bus.ready_o    <= 1'b0;
            bus.valid_o_tg <= 1'b0;
            for (int i = 0; i < `XH; i++) begin
                bus.vector_o[i] <= '0;
            end
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.ready_i_tg};

            pending  <= pending_nxt;
            fill_ptr <= fill_ptr_nxt;
            // ready_o looks at the next-cycle state so it never advertises a
            // buffer that is about to become pending; a freed buffer shows up
            // the cycle after its release.
            bus.ready_o <= ~pending_nxt[fill_ptr_nxt];

            if (close_buf) begin
                lane_cnt <= '0;
            end else if (accept) begin
                lane_cnt <= lane_cnt + LW'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (gap_cnt != 3'd0) begin
                        gap_cnt <= gap_cnt - 3'd1;
                    end
                    if (load_vec) begin
                        for (int i = 0; i < `XH; i++) begin
                            bus.vector_o[i] <= buf_mem[issue_ptr][i];
                        end
                        state <= ST_ARM;
                    end
                end
                // One cycle with the new vector already on vector_o before
                // the toggle, so the crossbar never samples a changing vector.
                ST_ARM: begin
                    bus.valid_o_tg <= ~bus.valid_o_tg;
                    state          <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (ready_pulse) begin
                        issue_ptr <= ~issue_ptr;
                        gap_cnt   <= 3'(ISSUE_GAP);
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef XBAR_FEEDER_STATS_EN
    // ---- statistics ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vec_cnt_o  <= 32'd0;
            pad_cnt_o  <= 32'd0;
            spurious_o <= 1'b0;
        end else begin
            if (release_buf) begin
                vec_cnt_o <= vec_cnt_o + 32'd1;
            end
            if (close_buf && bus.last_i && (lane_cnt != LW'(`XH - 1))) begin
                pad_cnt_o <= pad_cnt_o + 32'd1;
            end
            if (ready_pulse && (state != ST_WAIT)) begin
                spurious_o <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_xbar_feeder.sv
`ifndef XH
`define XH 4
`endif
`ifndef QW
`define QW 32
`endif

module tb_xbar_feeder;
    localparam int XH    = `XH;
    localparam int QW    = `QW;
    localparam int BOUND = 300;

    typedef logic [XH*QW-1:0] vec_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic busy;
`ifdef XBAR_FEEDER_STATS_EN
    logic [31:0] vec_cnt;
    logic [31:0] pad_cnt;
    logic        spurious;
`endif

    xbar_feeder_if bus ();

    xbar_feeder #(
        .SYNC_STAGES (2),
        .ISSUE_GAP   (1)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .busy_o     (busy)
`ifdef XBAR_FEEDER_STATS_EN
        ,
        .vec_cnt_o  (vec_cnt),
        .pad_cnt_o  (pad_cnt),
        .spurious_o (spurious)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: queue of complete expected vectors.
    vec_t           exp_q [$];
    logic [QW-1:0]  cur [XH];
    int             cur_n   = 0;
    int             pad_exp = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic vec_t out_vec();
        vec_t v;
        for (int i = 0; i < XH; i++) v[i*QW +: QW] = bus.vector_o[i];
        return v;
    endfunction

    function automatic vec_t mk4(input logic [QW-1:0] a, b, c, d);
        vec_t v = '0;
        v[0*QW +: QW] = a;
        v[1*QW +: QW] = b;
        v[2*QW +: QW] = c;
        v[3*QW +: QW] = d;
        return v;
    endfunction

    task automatic check_vec(input string tag, input vec_t exp);
        vec_t obs = out_vec();
        for (int i = 0; i < XH; i++)
            check($sformatf("%s_lane%0d", tag, i), 64'(obs[i*QW +: QW]), 64'(exp[i*QW +: QW]));
    endtask

    function automatic void model_accept(input logic [QW-1:0] d, input bit last);
        vec_t v = '0;
        cur[cur_n] = d;
        cur_n++;
        if (last || cur_n == XH) begin
            for (int i = 0; i < cur_n; i++) v[i*QW +: QW] = cur[i];
            exp_q.push_back(v);
            if (cur_n < XH) pad_exp++;
            cur_n = 0;
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        cur_n   = 0;
        pad_exp = 0;
    endfunction

    task automatic send(input logic [QW-1:0] d, input bit last);
        bit acc;
        int n = 0;
        bus.valid_i = 1'b1;
        bus.data_i  = d;
        bus.last_i  = last;
        do begin
            acc = bus.ready_o;
            step();
            n++;
        end while (!acc && n < BOUND);
        if (!acc) check("send_timeout", 0, 1);
        else model_accept(d, last);
        bus.valid_i = 1'b0;
        bus.last_i  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < BOUND) begin
            step();
            n++;
        end
        check(tag, 64'(busy), 0);
    endtask

    task automatic do_reset();
        bus.valid_i    = 1'b0;
        bus.last_i     = 1'b0;
        bus.data_i     = '0;
        bus.ready_i_tg = 1'b0;
        rstn = 1'b0;
        step(2);
        rstn = 1'b1;
        step();
        model_reset();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [QW-1:0] r0, r1, r2, r3;
        bit acc;

        bus.valid_i    = 1'b0;
        bus.last_i     = 1'b0;
        bus.data_i     = '0;
        bus.ready_i_tg = 1'b0;
        rstn           = 1'b0;

        // ---- reset state ----
        #3;
        check("rst_ready", 64'(bus.ready_o), 0);
        check("rst_vtg", 64'(bus.valid_o_tg), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_vec", 64'(out_vec()), 0);
        step(2);
        rstn = 1'b1;
        check("rel_ready_same", 64'(bus.ready_o), 0);
        step();
        check("rel_ready_next", 64'(bus.ready_o), 1);

        // ---- full vector 1.0..4.0 ----
        send(32'h3f800000, 0);
        send(32'h40000000, 0);
        send(32'h40400000, 0);
        send(32'h40800000, 0);
        check("full_busy", 64'(busy), 1);
        check("full_vtg_t0", 64'(bus.valid_o_tg), 0);
        step();
        check_vec("full_vec", mk4(32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000));
        check("full_vtg_t1", 64'(bus.valid_o_tg), 0);
        step();
        check("full_vtg_t2", 64'(bus.valid_o_tg), 1);
        bus.ready_i_tg = ~bus.ready_i_tg;
        step();
        check("full_busy_sync", 64'(busy), 1);
        step();
        check("full_busy_fall", 64'(busy), 0);
        check("full_ready", 64'(bus.ready_o), 1);

        // ---- partial vector 5.0,6.0 closed by last ----
        send(32'h40a00000, 0);
        send(32'h40c00000, 1);
        step();
        check_vec("part_vec", mk4(32'h40a00000, 32'h40c00000, 0, 0));
        check("part_vtg_t1", 64'(bus.valid_o_tg), 1);
        step();
        check("part_vtg_t2", 64'(bus.valid_o_tg), 0);
        bus.ready_i_tg = ~bus.ready_i_tg;
        wait_idle("part_idle");
`ifdef XBAR_FEEDER_STATS_EN
        check("part_pad_cnt", 64'(pad_cnt), 1);
        check("part_vec_cnt", 64'(vec_cnt), 2);
`endif

        // ---- stall: both buffers pending, crossbar silent ----
        k = 1;
        for (int c = 0; c < 16; c++) begin
            bus.valid_i = 1'b1;
            bus.data_i  = QW'(k);
            acc = bus.ready_o;
            step();
            if (acc) k++;
        end
        check("stall_accepted", 64'(k - 1), 8);
        check("stall_ready", 64'(bus.ready_o), 0);
        check("stall_vtg", 64'(bus.valid_o_tg), 1);
        check_vec("stall_vec1", mk4(1, 2, 3, 4));
        bus.ready_i_tg = ~bus.ready_i_tg;
        for (int c = 0; c < 60 && k <= 12; c++) begin
            bus.data_i = QW'(k);
            acc = bus.ready_o;
            step();
            if (acc) k++;
        end
        bus.valid_i = 1'b0;
        check("stall_resume", 64'(k - 1), 12);
        step(4);
        check("stall_vtg2", 64'(bus.valid_o_tg), 0);
        check_vec("stall_vec2", mk4(5, 6, 7, 8));
        check("stall_both_ready", 64'(bus.ready_o), 0);
        check("stall_both_busy", 64'(busy), 1);

        // ---- asynchronous reset in WAIT with both buffers pending ----
        #3;
        rstn = 1'b0;
        bus.ready_i_tg = 1'b0;
        #1;
        check("arst_ready", 64'(bus.ready_o), 0);
        check("arst_vtg", 64'(bus.valid_o_tg), 0);
        check("arst_busy", 64'(busy), 0);
        check("arst_vec", 64'(out_vec()), 0);
`ifdef XBAR_FEEDER_STATS_EN
        check("arst_vec_cnt", 64'(vec_cnt), 0);
`endif
        step();
        rstn = 1'b1;
        model_reset();
        step();
        check("arst_ready_rel", 64'(bus.ready_o), 1);
        r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
        send(r0, 0); send(r1, 0); send(r2, 0); send(r3, 0);
        step();
        check_vec("arst_vec_new", mk4(r0, r1, r2, r3));
        step();
        check("arst_vtg_new", 64'(bus.valid_o_tg), 1);
        bus.ready_i_tg = ~bus.ready_i_tg;
        wait_idle("arst_idle");

        // ---- spurious ready toggle in IDLE ----
`ifdef XBAR_FEEDER_STATS_EN
        check("spur_before", 64'(spurious), 0);
`endif
        bus.ready_i_tg = ~bus.ready_i_tg;
        step(6);
        check("spur_vtg", 64'(bus.valid_o_tg), 1);
        check("spur_busy", 64'(busy), 0);
        check("spur_ready", 64'(bus.ready_o), 1);
        check_vec("spur_vec_hold", mk4(r0, r1, r2, r3));
`ifdef XBAR_FEEDER_STATS_EN
        check("spur_flag", 64'(spurious), 1);
`endif

        // ---- randomized stream, 100 vectors, random crossbar latency ----
        do_reset();
        fork
            begin
                for (int v = 0; v < 100; v++) begin
                    int  len;
                    bit  lastf;
                    len   = $urandom_range(1, XH);
                    lastf = (len < XH) ? 1'b1 : 1'($urandom_range(0, 1));
                    for (int e = 0; e < len; e++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            bus.valid_i = 1'b0;
                            bus.last_i  = 1'($urandom_range(0, 1));
                            bus.data_i  = $urandom;
                            step($urandom_range(1, 3));
                            bus.last_i  = 1'b0;
                        end
                        send($urandom, (e == len - 1) ? lastf : 1'b0);
                    end
                end
            end
            begin
                logic prev;
                int   to;
                vec_t e;
                prev = bus.valid_o_tg;
                for (int n = 0; n < 100; n++) begin
                    to = 0;
                    while (bus.valid_o_tg == prev && to < 3000) begin
                        step();
                        to++;
                    end
                    if (bus.valid_o_tg == prev) begin
                        check("rnd_issue_timeout", 64'(n), 100);
                        break;
                    end
                    prev = bus.valid_o_tg;
                    if (exp_q.size() == 0) begin
                        check("rnd_unexpected_vec", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_vec($sformatf("rnd_v%0d", n), e);
                    end
                    step($urandom_range(0, 6));
                    bus.ready_i_tg = ~bus.ready_i_tg;
                end
            end
        join
        wait_idle("rnd_idle");
        check("rnd_queue_empty", 64'(exp_q.size()), 0);
        check("rnd_ready", 64'(bus.ready_o), 1);
`ifdef XBAR_FEEDER_STATS_EN
        check("rnd_vec_cnt", 64'(vec_cnt), 100);
        check("rnd_pad_cnt", 64'(pad_cnt), 64'(pad_exp));
        check("rnd_spurious", 64'(spurious), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
